// File: rtl/stream_mem_client_pkg.sv
// Shared types and constants for stream_mem_client and its address stepper.
// Holds the FSM state enum, interface widths and the SDRAM column-step constants.
package stream_mem_client_pkg;

    localparam int MEM_ADDR_W = 13;
    localparam int MEM_DATA_W = 64;
    localparam int STREAM_W   = 32;

    // Each 64-bit word occupies two 32-bit columns.
    localparam logic [9:0]            COL_STEP   = 10'd2;
    // Address bit 10 is never driven high toward the controller.
    localparam logic [MEM_ADDR_W-1:0] BIT10_MASK = 13'h0400;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_FILL_HI,
        ST_FILL_LO,
        ST_WR_GO,
        ST_WR_WAIT,
        ST_RD_GO,
        ST_RD_WAIT,
        ST_RD_OUT
    } state_t;

endpackage

// File: rtl/stream_mem_client_mem_addr_stepper.sv
// mem_addr_stepper: registered SDRAM address with load and advance.
// Advance adds two columns to bits [9:0]; a wrap past column 1022 carries into
// the bank bits [12:11], which wrap from 3 to 0. Bit 10 is held at 0.
// Ports:
//   clk, rst (async active-low)
//   load, load_addr  - load a new base (bit 10 is masked off)
//   advance          - step to the next 64-bit word
//   addr             - current address
module mem_addr_stepper
    import stream_mem_client_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [MEM_ADDR_W-1:0] load_addr,
    input  logic                  advance,
    output logic [MEM_ADDR_W-1:0] addr
);

    logic [10:0]           col_sum;
    logic [1:0]            bank_nxt;
    logic [MEM_ADDR_W-1:0] addr_nxt;

    always_comb begin
        col_sum  = {1'b0, addr[9:0]} + {1'b0, COL_STEP};
        bank_nxt = addr[12:11] + {1'b0, col_sum[10]};
        addr_nxt = {bank_nxt, 1'b0, col_sum[9:0]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_addr & ~BIT10_MASK;
        end else if (advance) begin
            addr <= addr_nxt;
        end
    end

endmodule

// File: rtl/stream_mem_client.sv
// stream_mem_client: requester-side client for the 64-bit SDRAM controller
// (go / w_rn / valid handshake). Packs a 32-bit input stream into 64-bit
// sequential writes and streams sequential reads out as ready/valid.
// The controller only samples go while idle and has no ready, so this block
// keeps exactly one transaction in flight and waits for valid before the next.
// Ports:
//   clk, rst (async active-low)
//   write session : wr_start, wr_base, in_data/in_valid/in_ready, wr_flush,
//                   words_written
//   read session  : rd_start, rd_base, rd_count, out_data/out_valid/out_ready,
//                   rd_done
//   status        : init_done, busy, err_timeout (timeout build only)
//   controller    : mem_go, mem_w_rn, mem_address, mem_data_wr, mem_data_rd,
//                   mem_valid
// Build option: define STREAM_MEM_CLIENT_TIMEOUT_EN to add the per-transaction
// watchdog and the sticky err_timeout output.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_INIT    | waiting INIT_WAIT cycles for controller power-up
// ST_IDLE    | no session; accepts wr_start / rd_start
// ST_FILL_HI | waiting for first stream word (goes to bits [63:32])
// ST_FILL_LO | waiting for second stream word or flush (bits [31:0])
// ST_WR_GO   | go pulse for a write
// ST_WR_WAIT | write in flight, waiting for mem_valid
// ST_RD_GO   | go pulse for a read
// ST_RD_WAIT | read in flight, waiting for mem_valid
// ST_RD_OUT  | read word presented, waiting for out_ready
module stream_mem_client
    import stream_mem_client_pkg::*;
#(
    parameter int                  INIT_WAIT = 6000,
    parameter logic [STREAM_W-1:0] PAD_WORD  = 32'h00000000
`ifdef STREAM_MEM_CLIENT_TIMEOUT_EN
    , parameter int                TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_start,
    input  logic [MEM_ADDR_W-1:0] wr_base,
    input  logic [STREAM_W-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wr_flush,
    input  logic                  rd_start,
    input  logic [MEM_ADDR_W-1:0] rd_base,
    input  logic [11:0]           rd_count,
    output logic [MEM_DATA_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  rd_done,
    output logic                  init_done,
    output logic                  busy,
    output logic [11:0]           words_written,
`ifdef STREAM_MEM_CLIENT_TIMEOUT_EN
    output logic                  err_timeout,
`endif
    output logic                  mem_go,
    output logic                  mem_w_rn,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [MEM_DATA_W-1:0] mem_data_wr,
    input  logic [MEM_DATA_W-1:0] mem_data_rd,
    input  logic                  mem_valid
);

    localparam int               INIT_W    = $clog2(INIT_WAIT + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_WAIT - 1);

    state_t                state, state_nxt;
    logic [INIT_W-1:0]     init_cnt;
    logic [MEM_DATA_W-1:0] wr_buf;
    logic                  flush_pend;
    logic                  sess_end;
    logic [11:0]           rd_rem;
    logic                  addr_load;
    logic                  addr_adv;
    logic                  tmo_hit;

`ifdef STREAM_MEM_CLIENT_TIMEOUT_EN
    localparam int              TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             in_wait;

    assign in_wait = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
    assign tmo_hit = in_wait && !mem_valid && (tmo_cnt == '0);

    // Down-counter reloads whenever no transaction is outstanding or valid arrives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt     <= TMO_LOAD;
            err_timeout <= 1'b0;
        end else if (in_wait && !mem_valid) begin
            tmo_cnt <= (tmo_cnt == '0) ? TMO_LOAD : tmo_cnt - TMO_W'(1);
            if (tmo_cnt == '0) err_timeout <= 1'b1;
        end else begin
            tmo_cnt <= TMO_LOAD;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // INIT is excluded so every output reads 0 out of reset; init_done covers it.
    assign busy        = (state != ST_IDLE) && (state != ST_INIT);
    assign mem_data_wr = wr_buf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_INIT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mem_go    = 1'b0;
        mem_w_rn  = 1'b0;
        addr_load = 1'b0;
        addr_adv  = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (wr_start) begin
                    state_nxt = ST_FILL_HI;
                    addr_load = 1'b1;
                end else if (rd_start && (rd_count != 12'd0)) begin
                    state_nxt = ST_RD_GO;
                    addr_load = 1'b1;
                end
            end
            ST_FILL_HI: begin
                in_ready = 1'b1;
                if (in_valid)      state_nxt = ST_FILL_LO;
                else if (wr_flush) state_nxt = ST_IDLE;
            end
            ST_FILL_LO: begin
                in_ready = 1'b1;
                if (in_valid || wr_flush || flush_pend) state_nxt = ST_WR_GO;
            end
            ST_WR_GO: begin
                mem_go    = 1'b1;
                mem_w_rn  = 1'b1;
                state_nxt = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                mem_w_rn = 1'b1;
                if (mem_valid) begin
                    addr_adv  = 1'b1;
                    state_nxt = (flush_pend || sess_end || wr_flush) ? ST_IDLE : ST_FILL_HI;
                end else if (tmo_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_GO: begin
                mem_go    = 1'b1;
                state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (mem_valid)    state_nxt = ST_RD_OUT;
                else if (tmo_hit) state_nxt = ST_IDLE;
            end
            ST_RD_OUT: begin
                if (out_ready) begin
                    addr_adv  = 1'b1;
                    state_nxt = (rd_rem == 12'd1) ? ST_IDLE : ST_RD_GO;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt      <= '0;
            init_done     <= 1'b0;
            wr_buf        <= '0;
            flush_pend    <= 1'b0;
            sess_end      <= 1'b0;
            words_written <= '0;
            rd_rem        <= '0;
            out_data      <= '0;
            out_valid     <= 1'b0;
            rd_done       <= 1'b0;
        end else begin
            rd_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + INIT_W'(1);
                    if (init_cnt == INIT_LAST) init_done <= 1'b1;
                end
                ST_IDLE: begin
                    if (wr_start) begin
                        words_written <= '0;
                        flush_pend    <= 1'b0;
                        sess_end      <= 1'b0;
                    end else if (rd_start) begin
                        rd_rem <= rd_count;
                        if (rd_count == 12'd0) rd_done <= 1'b1;
                    end
                end
                ST_FILL_HI: begin
                    // A flush alongside the first word is kept so the word gets padded.
                    if (in_valid) begin
                        wr_buf[63:32] <= in_data;
                        flush_pend    <= wr_flush;
                    end
                end
                ST_FILL_LO: begin
                    if (in_valid) begin
                        wr_buf[31:0] <= in_data;
                        flush_pend   <= flush_pend || wr_flush;
                    end else if (wr_flush || flush_pend) begin
                        wr_buf[31:0] <= PAD_WORD;
                        sess_end     <= 1'b1;
                    end
                end
                ST_WR_GO: begin
                    if (wr_flush) flush_pend <= 1'b1;
                end
                ST_WR_WAIT: begin
                    if (wr_flush) flush_pend <= 1'b1;
                    if (mem_valid && (words_written != 12'hFFF))
                        words_written <= words_written + 12'd1;
                end
                ST_RD_WAIT: begin
                    if (mem_valid) begin
                        out_data  <= mem_data_rd;
                        out_valid <= 1'b1;
                    end
                end
                ST_RD_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rd_rem    <= rd_rem - 12'd1;
                        if (rd_rem == 12'd1) rd_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_addr_stepper u_addr (
        .clk       (clk),
        .rst       (rst),
        .load      (addr_load),
        .load_addr (wr_start ? wr_base : rd_base),
        .advance   (addr_adv),
        .addr      (mem_address)
    );

endmodule

// File: tb/tb_stream_mem_client.sv
// Directed testbench for stream_mem_client with a small controller model that
// answers each mem_go with mem_valid a fixed number of cycles later.
module tb_stream_mem_client;

    localparam int INIT_WAIT = 6000;
    localparam int MEM_LAT   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_start = 1'b0;
    logic [12:0] wr_base = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        wr_flush = 1'b0;
    logic        rd_start = 1'b0;
    logic [12:0] rd_base = '0;
    logic [11:0] rd_count = '0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        rd_done;
    logic        init_done;
    logic        busy;
    logic [11:0] words_written;
    logic        mem_go;
    logic        mem_w_rn;
    logic [12:0] mem_address;
    logic [63:0] mem_data_wr;
    logic [63:0] mem_data_rd = '0;
    logic        mem_valid = 1'b0;
`ifdef STREAM_MEM_CLIENT_TIMEOUT_EN
    logic        err_timeout;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stream_mem_client dut (
        .clk           (clk),
        .rst           (rst),
        .wr_start      (wr_start),
        .wr_base       (wr_base),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .wr_flush      (wr_flush),
        .rd_start      (rd_start),
        .rd_base       (rd_base),
        .rd_count      (rd_count),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rd_done       (rd_done),
        .init_done     (init_done),
        .busy          (busy),
        .words_written (words_written),
`ifdef STREAM_MEM_CLIENT_TIMEOUT_EN
        .err_timeout   (err_timeout),
`endif
        .mem_go        (mem_go),
        .mem_w_rn      (mem_w_rn),
        .mem_address   (mem_address),
        .mem_data_wr   (mem_data_wr),
        .mem_data_rd   (mem_data_rd),
        .mem_valid     (mem_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Controller model: logs every go, checks hold of address/w_rn/data until valid.
    logic [12:0] go_addr[$];
    logic        go_w[$];
    logic [63:0] go_data[$];
    logic [63:0] rd_q[$];
    logic [12:0] m_addr;
    logic        m_w;
    logic [63:0] m_data;
    int          vld_cnt = 0;
    int          stab_err = 0;
    int          rd_done_cnt = 0;

    always begin
        @(negedge clk);
        if (mem_go === 1'b1) begin
            m_addr = mem_address;
            m_w    = mem_w_rn;
            m_data = mem_data_wr;
            go_addr.push_back(m_addr);
            go_w.push_back(m_w);
            go_data.push_back(m_data);
            for (int k = 0; k < MEM_LAT; k++) begin
                @(negedge clk);
                if (mem_address !== m_addr || mem_w_rn !== m_w || (m_w && mem_data_wr !== m_data))
                    stab_err++;
            end
            mem_data_rd = (rd_q.size() > 0) ? rd_q.pop_front() : 64'd0;
            mem_valid   = 1'b1;
            vld_cnt++;
            @(negedge clk);
            mem_valid = 1'b0;
        end
    end

    always @(posedge clk) if (rd_done === 1'b1) rd_done_cnt++;

    task automatic wait_valid(input int target);
        int n = 0;
        while (vld_cnt < target && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (vld_cnt < target) check("mem_valid_wait", 64'(vld_cnt), 64'(target));
        @(negedge clk);
    endtask

    // Called on a negedge with the DUT in FILL_HI.
    task automatic write_pair(input logic [31:0] hi, input logic [31:0] lo, input int target);
        in_valid = 1'b1;
        in_data  = hi;
        @(negedge clk);
        in_data = lo;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(target);
    endtask

    task automatic get_word(input logic [63:0] exp, input int stall);
        int n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("out_data", out_data, exp);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_data", out_data, exp);
            check("stall_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_mem_go", 64'(mem_go), 64'd0);
        check("rst_mem_address", 64'(mem_address), 64'd0);
        check("rst_words_written", 64'(words_written), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b1;

        // Init gating: wr_start during INIT is dropped, init_done rises at INIT_WAIT
        for (int i = 1; i <= INIT_WAIT; i++) begin
            @(negedge clk);
            if (i == 10) begin
                wr_start = 1'b1;
                in_valid = 1'b1;
                in_data  = 32'h5555_5555;
                wr_base  = 13'h100;
                check("init_in_ready", 64'(in_ready), 64'd0);
            end else begin
                wr_start = 1'b0;
                in_valid = 1'b0;
            end
            if (i == INIT_WAIT - 1) check("init_done_early", 64'(init_done), 64'd0);
            if (i == INIT_WAIT)     check("init_done_at", 64'(init_done), 64'd1);
        end
        check("init_no_go", 64'(go_addr.size()), 64'd0);
        check("init_idle", 64'(busy), 64'd0);

        // Write pair at address 0
        wr_base  = 13'h000;
        wr_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        check("fill_in_ready", 64'(in_ready), 64'd1);
        write_pair(32'h1111_1111, 32'h2222_2222, 1);
        check("wr0_addr", 64'(go_addr[0]), 64'h000);
        check("wr0_w_rn", 64'(go_w[0]), 64'd1);
        check("wr0_data", go_data[0], 64'h1111_1111_2222_2222);
        check("wr0_count", 64'(words_written), 64'd1);
        check("wr0_refill", 64'(in_ready), 64'd1);

        // Odd word then flush: padded low half, back to IDLE
        in_valid = 1'b1;
        in_data  = 32'hAAAA_AAAA;
        @(negedge clk);
        in_valid = 1'b0;
        wr_flush = 1'b1;
        @(negedge clk);
        wr_flush = 1'b0;
        check("flush_go", 64'(mem_go), 64'd1);
        wait_valid(2);
        check("flush_data", go_data[1], 64'hAAAA_AAAA_0000_0000);
        check("flush_addr", 64'(go_addr[1]), 64'h002);
        check("flush_idle", 64'(busy), 64'd0);
        check("flush_count", 64'(words_written), 64'd2);

        // Column wrap carries into the bank bits
        wr_base  = 13'h3FE;
        wr_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        write_pair(32'h0000_0001, 32'h0000_0002, 3);
        write_pair(32'h0000_0003, 32'h0000_0004, 4);
        wr_flush = 1'b1;
        @(negedge clk);
        wr_flush = 1'b0;
        check("wrap_addr0", 64'(go_addr[2]), 64'h3FE);
        check("wrap_addr1", 64'(go_addr[3]), 64'h800);
        check("wrap_count", 64'(words_written), 64'd2);
        check("wrap_idle", 64'(busy), 64'd0);

        // Read of three words with a five-cycle stall on the second
        rd_q.push_back(64'hA);
        rd_q.push_back(64'hB);
        rd_q.push_back(64'hC);
        rd_base  = 13'h004;
        rd_count = 12'd3;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        get_word(64'hA, 0);
        get_word(64'hB, 5);
        get_word(64'hC, 0);
        check("rd_done_pulse", 64'(rd_done), 64'd1);
        check("rd_idle", 64'(busy), 64'd0);
        @(negedge clk);
        check("rd_done_clear", 64'(rd_done), 64'd0);
        check("rd_addr0", 64'(go_addr[4]), 64'h004);
        check("rd_addr1", 64'(go_addr[5]), 64'h006);
        check("rd_addr2", 64'(go_addr[6]), 64'h008);
        check("rd_w_rn", 64'(go_w[4]), 64'd0);
        check("rd_done_once", 64'(rd_done_cnt), 64'd1);

        // Simultaneous starts: write wins, no read issued
        wr_base  = 13'h010;
        rd_base  = 13'h020;
        rd_count = 12'd2;
        wr_start = 1'b1;
        rd_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        rd_start = 1'b0;
        check("both_fill", 64'(in_ready), 64'd1);
        repeat (5) @(negedge clk);
        check("both_no_go", 64'(go_addr.size()), 64'd7);
        wr_flush = 1'b1;
        @(negedge clk);
        wr_flush = 1'b0;
        check("both_idle", 64'(busy), 64'd0);
        check("both_no_done", 64'(rd_done_cnt), 64'd1);

        // Zero-count read: rd_done only
        rd_count = 12'd0;
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check("zero_done", 64'(rd_done), 64'd1);
        check("zero_idle", 64'(busy), 64'd0);
        repeat (4) @(negedge clk);
        check("zero_no_go", 64'(go_addr.size()), 64'd7);
        check("zero_done_cnt", 64'(rd_done_cnt), 64'd2);

        // Base with bit 10 set in bank 3: bit forced low, bank wraps 3 -> 0
        rd_q.push_back(64'h1234);
        rd_q.push_back(64'h5678);
        rd_base   = 13'h1FFE;
        rd_count  = 12'd2;
        out_ready = 1'b1;
        rd_start  = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        for (int n = 0; n < 100 && busy === 1'b1; n++) @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        check("bank_addr0", 64'(go_addr[7]), 64'h1BFE);
        check("bank_addr1", 64'(go_addr[8]), 64'h0000);
        check("bank_last_data", out_data, 64'h5678);
        check("bank_done_cnt", 64'(rd_done_cnt), 64'd3);
        check("hold_stability", 64'(stab_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
